// File: rtl/srt4_prenorm.sv
// srt4_prenorm: operand pre-normalisation for an SRT radix-4 divider.
//   S1 strips signs and flags special cases; S2 counts leading zeros, normalises the
//   divisor, computes the radix-4 iteration count and resolves fixed results.
// Latency: 2 cycles accept->out_valid, throughput 1/cycle.
// Backpressure: out_valid & !out_ready holds S2; S1 moves only when S2 is empty or
//   draining; in_ready = !s1_valid | !s2_valid | out_ready (combinational, no skid).
// Ports: clk/rst (async active-low), in_valid/in_ready + dividend/divisor/sign in;
//   out_valid/out_ready + dvd_abs, dvs_norm, lzc_dvd, lzc_dvs, iter, q_neg, r_neg,
//   special, q_fix, r_fix out.
// Build option: SRT4_PRENORM_EARLY_OUT_EN resolves |dvd| < |dvs| as a fixed result
//   (q=0, r=dividend) instead of handing SRT4 a single iteration.
module srt4_prenorm #(
  parameter int WID = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WID-1:0]       dividend,
  input  logic [WID-1:0]       divisor,
  input  logic                 sign,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WID-1:0]       dvd_abs,
  output logic [WID-1:0]       dvs_norm,
  output logic [$clog2(WID):0] lzc_dvd,
  output logic [$clog2(WID):0] lzc_dvs,
  output logic [$clog2(WID):0] iter,
  output logic                 q_neg,
  output logic                 r_neg,
  output logic                 special,
  output logic [WID-1:0]       q_fix,
  output logic [WID-1:0]       r_fix
);

  localparam int LZW = $clog2(WID) + 1;
  localparam logic [WID-1:0] MIN_INT = {1'b1, {(WID-1){1'b0}}};

  // Leading-zero count; returns WID for an all-zero operand.
  function automatic logic [LZW-1:0] lzc(input logic [WID-1:0] x);
    logic [LZW-1:0] n;
    n = LZW'(WID);
    for (int i = 0; i < WID; i++) begin
      if (x[i]) n = LZW'(WID - 1 - i);
    end
    return n;
  endfunction

  // ---------------- handshake ----------------
  logic s1_vld_q, s2_vld_q;
  logic accept, s2_take;

  assign in_ready = ~s1_vld_q | ~s2_vld_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign s2_take  = s1_vld_q & (~s2_vld_q | out_ready);

  // ---------------- S1: sign strip ----------------
  logic [WID-1:0] dvd_abs_d, dvs_abs_d;
  logic           ovf_d;
  logic [WID-1:0] s1_dvd_abs_q, s1_dvs_abs_q, s1_dvd_raw_q;
  logic           s1_q_neg_q, s1_r_neg_q, s1_ovf_q;

  // Two's-complement negation of MIN_INT yields MIN_INT, i.e. 2^(WID-1) unsigned.
  assign dvd_abs_d = (sign && dividend[WID-1]) ? (~dividend + 1'b1) : dividend;
  assign dvs_abs_d = (sign && divisor[WID-1])  ? (~divisor + 1'b1)  : divisor;
  assign ovf_d     = sign && (dividend == MIN_INT) && (&divisor);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q     <= 1'b0;
      s1_dvd_abs_q <= '0;
      s1_dvs_abs_q <= '0;
      s1_dvd_raw_q <= '0;
      s1_q_neg_q   <= 1'b0;
      s1_r_neg_q   <= 1'b0;
      s1_ovf_q     <= 1'b0;
    end else if (accept) begin
      s1_vld_q     <= 1'b1;
      s1_dvd_abs_q <= dvd_abs_d;
      s1_dvs_abs_q <= dvs_abs_d;
      s1_dvd_raw_q <= dividend;
      s1_q_neg_q   <= sign & (dividend[WID-1] ^ divisor[WID-1]);
      s1_r_neg_q   <= sign & dividend[WID-1];
      s1_ovf_q     <= ovf_d;
    end else if (s2_take) begin
      s1_vld_q <= 1'b0;
    end
  end

  // ---------------- S2: normalise + special resolution ----------------
  logic [LZW-1:0] lz_a, lz_b;
  logic [WID-1:0] dvs_norm_d, q_fix_d, r_fix_d;
  logic [LZW-1:0] lzc_dvd_d, lzc_dvs_d, iter_d;
  logic           special_d;

  assign lz_a = lzc(s1_dvd_abs_q);
  assign lz_b = lzc(s1_dvs_abs_q);

  always_comb begin
    special_d  = 1'b0;
    q_fix_d    = '0;
    r_fix_d    = '0;
    dvs_norm_d = s1_dvs_abs_q << lz_b;
    lzc_dvd_d  = lz_a;
    lzc_dvs_d  = lz_b;
    // Each radix-4 step retires two quotient bits.
    iter_d     = ((lz_b - lz_a) >> 1) + LZW'(1);
    if (s1_dvs_abs_q == '0) begin
      special_d = 1'b1;
      q_fix_d   = '1;
      r_fix_d   = s1_dvd_raw_q;
    end else if (s1_ovf_q) begin
      special_d = 1'b1;
      q_fix_d   = MIN_INT;
    end else if (s1_dvd_abs_q == '0) begin
      special_d = 1'b1;
    end else if (lz_b < lz_a) begin
`ifdef SRT4_PRENORM_EARLY_OUT_EN
      special_d = 1'b1;
      r_fix_d   = s1_dvd_raw_q;
`else
      iter_d    = LZW'(1);
`endif
    end
    if (special_d) begin
      dvs_norm_d = '0;
      lzc_dvd_d  = '0;
      lzc_dvs_d  = '0;
      iter_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld_q <= 1'b0;
      dvd_abs  <= '0;
      dvs_norm <= '0;
      lzc_dvd  <= '0;
      lzc_dvs  <= '0;
      iter     <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      special  <= 1'b0;
      q_fix    <= '0;
      r_fix    <= '0;
    end else if (s2_take) begin
      s2_vld_q <= 1'b1;
      dvd_abs  <= s1_dvd_abs_q;
      dvs_norm <= dvs_norm_d;
      lzc_dvd  <= lzc_dvd_d;
      lzc_dvs  <= lzc_dvs_d;
      iter     <= iter_d;
      q_neg    <= s1_q_neg_q;
      r_neg    <= s1_r_neg_q;
      special  <= special_d;
      q_fix    <= q_fix_d;
      r_fix    <= r_fix_d;
    end else if (out_ready) begin
      s2_vld_q <= 1'b0;
    end
  end

  assign out_valid = s2_vld_q;

endmodule

// File: tb/tb_srt4_prenorm.sv
module tb_srt4_prenorm;
  localparam int WID = 64;
  localparam logic [63:0] MIN_INT = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sign, out_valid, out_ready;
  logic [63:0] dividend, divisor, dvd_abs, dvs_norm, q_fix, r_fix;
  logic [6:0]  lzc_dvd, lzc_dvs, iter;
  logic        q_neg, r_neg, special;

  srt4_prenorm #(.WID(WID)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .sign(sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .dvd_abs(dvd_abs), .dvs_norm(dvs_norm), .lzc_dvd(lzc_dvd), .lzc_dvs(lzc_dvs),
    .iter(iter), .q_neg(q_neg), .r_neg(r_neg), .special(special),
    .q_fix(q_fix), .r_fix(r_fix)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] dvd_abs, dvs_norm, q_fix, r_fix;
    int          lzc_dvd, lzc_dvs, iter;
    logic        q_neg, r_neg, special;
  } exp_t;

  exp_t expq[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  int   popped  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Leading zeros by shifting until the top bit is set.
  function automatic int nlz(input logic [63:0] x);
    int n = 0;
    if (x == 64'd0) return 64;
    while (!x[63]) begin
      x = x << 1;
      n++;
    end
    return n;
  endfunction

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic s);
    exp_t e;
    logic [63:0] aa, bb;
    int ld, lv;
    aa = (s && a[63]) ? 64'd0 - a : a;
    bb = (s && b[63]) ? 64'd0 - b : b;
    e.dvd_abs = aa;
    e.q_neg = s & (a[63] ^ b[63]);
    e.r_neg = s & a[63];
    e.special = 1'b0; e.q_fix = 0; e.r_fix = 0;
    e.dvs_norm = 0; e.lzc_dvd = 0; e.lzc_dvs = 0; e.iter = 0;
    ld = nlz(aa);
    lv = nlz(bb);
    if (b == 0) begin
      e.special = 1'b1; e.q_fix = '1; e.r_fix = a;
    end else if (s && a == MIN_INT && b == '1) begin
      e.special = 1'b1; e.q_fix = MIN_INT;
    end else if (a == 0) begin
      e.special = 1'b1;
    end else if (lv < ld) begin
`ifdef SRT4_PRENORM_EARLY_OUT_EN
      e.special = 1'b1; e.r_fix = a;
`else
      e.lzc_dvd = ld; e.lzc_dvs = lv; e.dvs_norm = bb << lv; e.iter = 1;
`endif
    end else begin
      e.lzc_dvd = ld; e.lzc_dvs = lv; e.dvs_norm = bb << lv;
      e.iter = (lv - ld) / 2 + 1;
    end
    return e;
  endfunction

  // Compare process: every cycle the outputs are valid, check against the oldest
  // outstanding operation; record accepted operations.
  always @(negedge clk) begin
    if (!rst) begin
      expq.delete();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    end else begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          cmp_cnt++; err_cnt++;
          $display("FAIL unexpected_output: got out_valid=1, expected no pending op (t=%0t)", $time);
        end else begin
          chk("m_dvd_abs",  dvd_abs,  expq[0].dvd_abs);
          chk("m_dvs_norm", dvs_norm, expq[0].dvs_norm);
          chk("m_lzc_dvd",  64'(lzc_dvd), 64'(expq[0].lzc_dvd));
          chk("m_lzc_dvs",  64'(lzc_dvs), 64'(expq[0].lzc_dvs));
          chk("m_iter",     64'(iter),    64'(expq[0].iter));
          chk("m_q_neg",    64'(q_neg),   64'(expq[0].q_neg));
          chk("m_r_neg",    64'(r_neg),   64'(expq[0].r_neg));
          chk("m_special",  64'(special), 64'(expq[0].special));
          chk("m_q_fix",    q_fix,    expq[0].q_fix);
          chk("m_r_fix",    r_fix,    expq[0].r_fix);
          if (out_ready) begin
            void'(expq.pop_front());
            popped++;
          end
        end
      end
      if (in_valid && in_ready) expq.push_back(model(dividend, divisor, sign));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic s);
    int n = 0;
    dividend = a; divisor = b; sign = s; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      cmp_cnt++; err_cnt++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
  endtask

  logic [63:0] vec_a [10] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                              64'd0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd77,
                              64'hFFFF_FFFF_FFFF_FFF0, 64'd1000};
  logic [63:0] vec_b [10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
                              64'd5, 64'd0, 64'd1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'd4, 64'd3};
  logic        vec_s [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  bit rnd_done;

  function automatic logic [63:0] rnd_operand();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: v = v >> $urandom_range(0, 63);
      1: v = (v == 0) ? 64'd0 : v;
      2: v = ($urandom_range(0, 1) == 1) ? 64'd0 : '1;
      default: v = v >> $urandom_range(32, 62);
    endcase
    return v;
  endfunction

  initial begin
    int n, p0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    dividend = 0; divisor = 0; sign = 0;
    #1;
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_dvd_abs",   dvd_abs, 64'd0);
    chk("reset_dvs_norm",  dvs_norm, 64'd0);
    chk("reset_q_fix",     q_fix, 64'd0);
    chk("reset_special",   64'(special), 64'd0);
    chk("reset_iter",      64'(iter), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // unsigned 100/7
    send(64'd100, 64'd7, 1'b0);
    wait_out(n);
    chk("t1_latency", 64'(n), 64'd2);
    chk("t1_dvd_abs", dvd_abs, 64'd100);
    chk("t1_lzc_dvd", 64'(lzc_dvd), 64'd57);
    chk("t1_lzc_dvs", 64'(lzc_dvs), 64'd61);
    chk("t1_dvs_norm", dvs_norm, 64'hE000_0000_0000_0000);
    chk("t1_iter", 64'(iter), 64'd3);
    chk("t1_q_neg", 64'(q_neg), 64'd0);
    chk("t1_special", 64'(special), 64'd0);
    @(posedge clk); #1;

    // signed -100/7 and 100/-7
    send(-64'sd100, 64'd7, 1'b1);
    wait_out(n);
    chk("t2a_dvd_abs", dvd_abs, 64'd100);
    chk("t2a_q_neg", 64'(q_neg), 64'd1);
    chk("t2a_r_neg", 64'(r_neg), 64'd1);
    chk("t2a_iter", 64'(iter), 64'd3);
    @(posedge clk); #1;
    send(64'd100, -64'sd7, 1'b1);
    wait_out(n);
    chk("t2b_q_neg", 64'(q_neg), 64'd1);
    chk("t2b_r_neg", 64'(r_neg), 64'd0);
    @(posedge clk); #1;

    // divide by zero; signed overflow
    send(64'h1234, 64'd0, 1'b0);
    wait_out(n);
    chk("t3a_special", 64'(special), 64'd1);
    chk("t3a_q_fix", q_fix, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3a_r_fix", r_fix, 64'h1234);
    chk("t3a_dvs_norm", dvs_norm, 64'd0);
    @(posedge clk); #1;
    send(MIN_INT, '1, 1'b1);
    wait_out(n);
    chk("t3b_special", 64'(special), 64'd1);
    chk("t3b_q_fix", q_fix, MIN_INT);
    chk("t3b_r_fix", r_fix, 64'd0);
    @(posedge clk); #1;

    // |dvd| < |dvs|
    send(64'd5, 64'd9, 1'b0);
    wait_out(n);
`ifdef SRT4_PRENORM_EARLY_OUT_EN
    chk("t4_special", 64'(special), 64'd1);
    chk("t4_q_fix", q_fix, 64'd0);
    chk("t4_r_fix", r_fix, 64'd5);
`else
    chk("t4_special", 64'(special), 64'd0);
    chk("t4_iter", 64'(iter), 64'd1);
`endif
    @(posedge clk); #1;

    // back-to-back edge vectors, model-checked
    for (int i = 0; i < 10; i++) send(vec_a[i], vec_b[i], vec_s[i]);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;

    // stall with both stages full
    p0 = popped;
    out_ready = 1'b0;
    send(64'd300, 64'd3, 1'b0);
    send(64'd40, 64'd6, 1'b0);
    fork
      send(64'd9000, 64'd11, 1'b0);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("t5_in_ready", 64'(in_ready), 64'd0);
          chk("t5_out_valid", 64'(out_valid), 64'd1);
          chk("t5_hold", dvd_abs, 64'd300);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    chk("t5_emitted", 64'(popped - p0), 64'd3);
    @(posedge clk); #1;

    // reset while an op sits in S1
    send(64'd555, 64'd5, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t6_no_output", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(64'd12345, 64'd10, 1'b0);
    wait_out(n);
    chk("t6_latency", 64'(n), 64'd2);
    chk("t6_dvd_abs", dvd_abs, 64'd12345);
    chk("t6_lzc_dvd", 64'(lzc_dvd), 64'd50);
    chk("t6_lzc_dvs", 64'(lzc_dvs), 64'd60);
    chk("t6_iter", 64'(iter), 64'd6);
    @(posedge clk); #1;

    // random operands under random backpressure, model-checked
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 60; k++) send(rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("drain_empty", 64'(expq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000, expected finish");
    err_cnt++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $fatal(1, "watchdog");
  end

endmodule
